// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and the byte-wide reflected CRC-32 step
// for the streaming Ethernet CRC engine.
package crc32_pkg;

    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } crc_state_e;

    // Eight bit steps, LSB of the byte first; the loop fully unrolls.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC32_POLY_REFL : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_lane_chain.sv
// Combinational CRC update over one beat: byte lanes applied in ascending
// order, lanes with keep=0 pass the CRC through unchanged.
module crc32_lane_chain
    import crc32_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic [KEEP_W-1:0] keep,
    output logic [31:0]       crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < KEEP_W; i++) begin
            if (keep[i]) begin
                c = crc32_byte(c, data[8*i +: 8]);
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: frame FSM, running CRC register and registered
// per-frame results (FCS for TX, residue check for RX).
module crc32_stream
    import crc32_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [31:0]       out_fcs,
    output logic              out_ok,
    output logic              out_err,
    output logic              busy
);

    crc_state_e  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_fcs_q, out_fcs_d;
    logic        out_ok_q, out_ok_d;
    logic        out_err_q, out_err_d;

    logic [31:0] step_base;
    logic [31:0] step_crc;

    // A sop beat always restarts from INIT, even when it aborts an open frame.
    assign step_base = (state_q == ST_FRAME && !in_sop) ? crc_q : CRC32_INIT;

    crc32_lane_chain #(.DATA_W(DATA_W)) u_chain (
        .crc_in  (step_base),
        .data    (in_data),
        .keep    (in_keep),
        .crc_out (step_crc)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        out_fcs_d   = out_fcs_q;
        out_ok_d    = out_ok_q;

        if (in_valid) begin
            if (in_sop || state_q == ST_FRAME) begin
                crc_d = step_crc;
                if (in_sop && state_q == ST_FRAME) begin
                    out_err_d = 1'b1;
                end
                if (in_eop) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    out_fcs_d   = ~step_crc;
                    out_ok_d    = (step_crc == CRC32_RESIDUE);
                end else begin
                    state_d = ST_FRAME;
                end
            end else begin
                // Stray beat outside a frame: dropped, CRC untouched.
                out_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= CRC32_INIT;
            out_valid_q <= 1'b0;
            out_fcs_q   <= 32'h0;
            out_ok_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            out_valid_q <= out_valid_d;
            out_fcs_q   <= out_fcs_d;
            out_ok_q    <= out_ok_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fcs   = out_fcs_q;
    assign out_ok    = out_ok_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q == ST_FRAME);

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream at both datapath widths: directed vector table,
// hand-written framing corner cases and random frames against a bit-serial CRC.
module tb_crc32_stream;

    logic clk = 1'b0;
    logic rst_n;

    logic        v32, sop32, eop32;
    logic [3:0]  keep32;
    logic [31:0] data32;
    logic        ov32, ok32, err32, busy32;
    logic [31:0] fcs32;

    logic        v64, sop64, eop64;
    logic [7:0]  keep64;
    logic [63:0] data64;
    logic        ov64, ok64, err64, busy64;
    logic [31:0] fcs64;

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_b [0:1599];

    always #5 clk = ~clk;

    crc32_stream #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_sop(sop32), .in_eop(eop32),
        .in_keep(keep32), .in_data(data32), .out_valid(ov32), .out_fcs(fcs32),
        .out_ok(ok32), .out_err(err32), .busy(busy32)
    );

    crc32_stream #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_sop(sop64), .in_eop(eop64),
        .in_keep(keep64), .in_data(data64), .out_valid(ov64), .out_fcs(fcs64),
        .out_ok(ok64), .out_err(err64), .busy(busy64)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [31:0] fcs;
        logic        ok;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat64(input logic s, input logic e, input logic [7:0] k, input logic [63:0] d);
        v64 = 1'b1; sop64 = s; eop64 = e; keep64 = k; data64 = d;
        @(posedge clk); #1;
        v64 = 1'b0; sop64 = 1'b0; eop64 = 1'b0;
    endtask

    task automatic beat32(input logic s, input logic e, input logic [3:0] k, input logic [31:0] d);
        v32 = 1'b1; sop32 = s; eop32 = e; keep32 = k; data32 = d;
        @(posedge clk); #1;
        v32 = 1'b0; sop32 = 1'b0; eop32 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] ref_fcs(input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                c = (c >> 1) ^ ((c[0] ^ frame_b[i][b]) ? 32'hEDB8_8320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    task automatic rand_frames(input int lanes, input int nframes);
        int          len, pos, nb;
        logic        first, last;
        logic [63:0] d;
        logic [7:0]  k;
        logic [31:0] exp;
        for (int f = 0; f < nframes; f++) begin
            len = $urandom_range(1, 1600);
            for (int i = 0; i < len; i++) frame_b[i] = 8'($urandom);
            exp   = ref_fcs(len);
            pos   = 0;
            first = 1'b1;
            while (pos < len) begin
                nb = (len - pos < lanes) ? len - pos : lanes;
                d  = {$urandom, $urandom};
                k  = 8'h0;
                for (int j = 0; j < nb; j++) begin
                    d[8*j +: 8] = frame_b[pos + j];
                    k[j]        = 1'b1;
                end
                pos += nb;
                last = (pos >= len);
                idle($urandom_range(0, 2));
                if (lanes == 8) beat64(first, last, k, d);
                else            beat32(first, last, k[3:0], d[31:0]);
                first = 1'b0;
            end
            if (lanes == 8) begin
                chk($sformatf("rand64[%0d] valid", f), {31'h0, ov64}, 32'h1);
                chk($sformatf("rand64[%0d] fcs len=%0d", f, len), fcs64, exp);
            end else begin
                chk($sformatf("rand32[%0d] valid", f), {31'h0, ov32}, 32'h1);
                chk($sformatf("rand32[%0d] fcs len=%0d", f, len), fcs32, exp);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{64'hDEAD_BEEF_CAFE_1231, 8'h01, 32'h83DC_EFB7, 1'b0};
        tbl[1] = '{64'hA5A5_A5A5_A5_333231, 8'h07, 32'h8848_63D2, 1'b0};
        tbl[2] = '{64'h1122_3344_3433_3231, 8'h0F, 32'h9BE3_E0A3, 1'b0};
        tbl[3] = '{64'hFFFF_FF35_3433_3231, 8'h1F, 32'hCBF5_3A1C, 1'b0};
        tbl[4] = '{64'h3837_3635_3433_3231, 8'hFF, 32'h9AE0_DAAF, 1'b0};
        tbl[5] = '{64'h0123_4567_89AB_CD61, 8'h01, 32'hE8B7_BE43, 1'b0};
        tbl[6] = '{64'h0000_0000_0063_6261, 8'h07, 32'h3524_41C2, 1'b0};
        tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 32'h0000_0000, 1'b0};
        tbl[8] = '{64'h9BE3_E0A3_3433_3231, 8'hFF, 32'h2144_DF1C, 1'b1};

        rst_n = 1'b0;
        v32 = 0; sop32 = 0; eop32 = 0; keep32 = '0; data32 = '0;
        v64 = 0; sop64 = 0; eop64 = 0; keep64 = '0; data64 = '0;
        idle(3);
        chk("reset ov64",   {31'h0, ov64},   32'h0);
        chk("reset err64",  {31'h0, err64},  32'h0);
        chk("reset busy64", {31'h0, busy64}, 32'h0);
        chk("reset fcs64",  fcs64,           32'h0);
        chk("reset ok64",   {31'h0, ok64},   32'h0);
        chk("reset ov32",   {31'h0, ov32},   32'h0);
        chk("reset fcs32",  fcs32,           32'h0);
        rst_n = 1'b1;
        idle(1);

        // Single-beat frames from the table, back to back.
        for (int i = 0; i < 9; i++) begin
            beat64(1'b1, 1'b1, tbl[i].keep, tbl[i].data);
            chk($sformatf("tbl[%0d] valid", i), {31'h0, ov64},  32'h1);
            chk($sformatf("tbl[%0d] fcs", i),   fcs64,          tbl[i].fcs);
            chk($sformatf("tbl[%0d] ok", i),    {31'h0, ok64},  {31'h0, tbl[i].ok});
            chk($sformatf("tbl[%0d] err", i),   {31'h0, err64}, 32'h0);
        end
        idle(1);
        chk("valid one-shot", {31'h0, ov64}, 32'h0);
        chk("fcs held",       fcs64,         32'h2144_DF1C);

        // 32-bit "123456789" with a gap inside the frame.
        beat32(1'b1, 1'b0, 4'hF, 32'h3433_3231);
        chk("w32 busy after sop", {31'h0, busy32}, 32'h1);
        chk("w32 no early valid", {31'h0, ov32},   32'h0);
        idle(2);
        chk("w32 busy in gap", {31'h0, busy32}, 32'h1);
        beat32(1'b0, 1'b0, 4'hF, 32'h3837_3635);
        beat32(1'b0, 1'b1, 4'h1, 32'hEEEE_EE39);
        chk("w32 check valid", {31'h0, ov32},   32'h1);
        chk("w32 check fcs",   fcs32,           32'hCBF4_3926);
        chk("w32 busy clear",  {31'h0, busy32}, 32'h0);

        // RX residue check, then the same frame with one bit flipped.
        beat64(1'b1, 1'b0, 8'hFF, 64'h3837_3635_3433_3231);
        beat64(1'b0, 1'b1, 8'h1F, 64'h0000_00CB_F439_2639);
        chk("rx good valid", {31'h0, ov64}, 32'h1);
        chk("rx good ok",    {31'h0, ok64}, 32'h1);
        chk("rx good fcs",   fcs64,         32'h2144_DF1C);
        beat64(1'b1, 1'b0, 8'hFF, 64'h3837_3635_3433_3230);
        beat64(1'b0, 1'b1, 8'h1F, 64'h0000_00CB_F439_2639);
        chk("rx bad valid", {31'h0, ov64}, 32'h1);
        chk("rx bad ok",    {31'h0, ok64}, 32'h0);

        // Three single-beat frames on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            beat64(1'b1, 1'b1, 8'hFF, 64'h3837_3635_3433_3231);
            chk($sformatf("b2b[%0d] valid", i), {31'h0, ov64}, 32'h1);
            chk($sformatf("b2b[%0d] fcs", i),   fcs64,         32'h9AE0_DAAF);
        end
        idle(1);

        // sop before eop aborts; restarted frame ends on a keep-zero eop.
        beat64(1'b1, 1'b0, 8'hFF, 64'h4141_4141_4141_4141);
        chk("abort no err yet", {31'h0, err64}, 32'h0);
        beat64(1'b1, 1'b0, 8'hFF, 64'h3837_3635_3433_3231);
        chk("abort err",      {31'h0, err64},  32'h1);
        chk("abort no valid", {31'h0, ov64},   32'h0);
        chk("abort busy",     {31'h0, busy64}, 32'h1);
        beat64(1'b0, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("restart valid", {31'h0, ov64},  32'h1);
        chk("restart fcs",   fcs64,          32'h9AE0_DAAF);
        chk("restart err",   {31'h0, err64}, 32'h0);

        // Abort beat that is itself sop+eop: err and valid together.
        beat64(1'b1, 1'b0, 8'hFF, 64'h4242_4242_4242_4242);
        beat64(1'b1, 1'b1, 8'h0F, 64'h0000_0000_3433_3231);
        chk("abort1 err",   {31'h0, err64}, 32'h1);
        chk("abort1 valid", {31'h0, ov64},  32'h1);
        chk("abort1 fcs",   fcs64,          32'h9BE3_E0A3);

        // Stray beat while idle.
        beat64(1'b0, 1'b1, 8'hFF, 64'h1234_5678_9ABC_DEF0);
        chk("stray err",   {31'h0, err64},  32'h1);
        chk("stray valid", {31'h0, ov64},   32'h0);
        chk("stray busy",  {31'h0, busy64}, 32'h0);
        chk("stray fcs",   fcs64,           32'h9BE3_E0A3);
        idle(1);
        chk("stray err one-shot", {31'h0, err64}, 32'h0);

        // One-cycle reset mid-frame.
        beat64(1'b1, 1'b0, 8'hFF, 64'h5555_5555_5555_5555);
        chk("pre-reset busy", {31'h0, busy64}, 32'h1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("mid reset busy",  {31'h0, busy64}, 32'h0);
        chk("mid reset valid", {31'h0, ov64},   32'h0);
        idle(1);
        chk("post reset valid", {31'h0, ov64}, 32'h0);
        beat64(1'b1, 1'b1, 8'hFF, 64'h3837_3635_3433_3231);
        chk("post reset fcs", fcs64, 32'h9AE0_DAAF);

        idle(1);
        rand_frames(8, 8);
        idle(1);
        rand_frames(4, 8);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc32_stream.md
# crc32_stream

Streaming Ethernet CRC-32 engine for the ether10g MAC datapath, parametrised in datapath width. It is the successor to the fixed 32-bit combinational CRC step. It accumulates the CRC over multi-beat frames and handles partial final beats via per-byte keep. It either generates the FCS on TX or checks the residue on RX. It sits beside the MAC framer and deparser, registered, one result per frame.

## Interface
Parameters:
- DATA_W, 64, datapath width in bits; legal values are 32 and 64.
- KEEP_W, DATA_W/8, number of byte lanes; derived, not overridable.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  beat qualifier.
- in_sop  in  1  first beat of frame; valid only with in_valid.
- in_eop  in  1  last beat of frame; valid only with in_valid.
- in_keep  in  KEEP_W  byte-lane enables; lane 0 = in_data[7:0] = earliest byte on the wire.
- in_data  in  DATA_W  frame bytes.
- out_valid  out  1  one-cycle pulse, result for the completed frame.
- out_fcs  out  32  FCS = ~crc; transmitted lane order is out_fcs[7:0] first.
- out_ok  out  1  running CRC register == residue 32'hDEBB20E3 (RX check); meaningful with out_valid.
- out_err  out  1  one-cycle pulse on a framing violation.
- busy  out  1  high while a frame is open (sop accepted, eop not yet seen).

## Operation
- CRC is reflected IEEE 802.3: init 32'hFFFFFFFF, polynomial 32'hEDB88320.
- Per-bit update, LSB of each byte first: fb = c[0]^d; c = (c>>1) ^ (fb ? POLY : 0).
- Lanes are processed in ascending order. A lane with keep=0 is skipped and the CRC passes through unchanged.
- Keep must be contiguous from lane 0 on the eop beat and all-ones otherwise. Non-contiguous keep is processed as given, with no error.
- Frame state: IDLE / FRAME, reflected on busy.
  - IDLE + valid&sop: crc <= step(INIT, beat). Next state is FRAME; if eop is also set, the frame completes on this beat and the state stays IDLE.
  - FRAME + valid & !sop: crc <= step(crc, beat).
  - FRAME + valid & eop: the result is issued and the next state is IDLE.
  - FRAME + valid&sop (sop before eop): the open frame is aborted with out_err and no out_valid. The new frame restarts from INIT with this beat.
  - IDLE + valid & !sop: beat dropped, out_err pulse, crc unchanged.
  - !in_valid: hold everything. Gaps are allowed anywhere inside a frame.
- An eop beat with keep all-zero completes the frame using the CRC accumulated before that beat.
- out_fcs and out_ok both derive from the same final register value. The user selects TX or RX use; both modes are always available.

## Timing
- Reset values: out_valid=0, out_err=0, busy=0, out_fcs=32'h0, out_ok=0. The internal crc resets to INIT.
- Latency: out_valid, out_fcs and out_ok are registered and appear on the cycle after the eop beat.
- out_fcs and out_ok hold until the next out_valid.
- Throughput: one beat per cycle with no backpressure (no ready). Back-to-back frames work: eop then sop on the next cycle, or single-beat sop+eop frames on consecutive cycles.
- out_err is registered, one cycle after the offending beat. If the abort beat is itself sop+eop, out_err and out_valid pulse together.
- Reset while a frame is open: the frame is discarded, no output pulse, and the state returns to IDLE.
- Critical path: KEEP_W chained byte steps with muxes. This must meet 156.25 MHz at DATA_W=64.

## Structure
- Package crc32_pkg holds:
  - CRC32_INIT, CRC32_POLY_REFL and CRC32_RESIDUE constants;
  - the function crc32_byte(crc, byte) that implements 8 unrolled bit steps.
- Sub-module crc32_lane_chain is combinational. It takes crc_in, data and keep, and chains KEEP_W instances of crc32_byte with per-lane bypass.
- crc32_stream holds the FSM, the crc register and the output registers.

## Test plan
- DATA_W=32, "123456789" sent as 0x34333231/keep F sop, then 0x38373635/keep F, then 0x00000039/keep 1 eop -> out_valid one cycle after the eop beat, out_fcs=32'hCBF43926.
- DATA_W=64, RX check: 0x3837363534333231/keep FF sop, then 0x000000CBF4392639/keep 1F eop -> out_ok=1, out_fcs=32'h2144DF1C.
  - Same frame with one data bit flipped -> out_ok=0.
- Single-beat sop+eop frames on 3 consecutive cycles (DATA_W=64, "12345678", keep FF) -> 3 consecutive out_valid pulses, each with out_fcs=32'h9AE0DAAF.
- sop, then a second sop before eop -> out_err pulse, no out_valid for the first frame.
  - The second frame then yields the correct FCS.
  - A valid beat without sop while IDLE -> out_err pulse and no state change.
- rst_n=0 for one cycle mid-frame -> busy=0, no out_valid.
  - The next frame's FCS must equal a fresh-frame golden value.
- Random frames of 1–1600 bytes with random in_valid gaps, both widths -> out_fcs matches a reference-model CRC-32 for every frame.
